// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-SRAM port arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        WB_ACK = 1'b1
    } arb_state_t;

    // Deselected levels of the active-low SRAM controls
    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_IDLE = 1'b1;

    // Default geometry: 256 words, window at 0x3000_0000
    localparam int unsigned DMEM_AW   = 8;
    localparam logic [31:0] DMEM_BASE = 32'h3000_0000;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single read/write port of the data SRAM between the core
// (default priority) and the Wishbone slave. A starvation counter forces a
// Wishbone win after STARVE_LIM lost cycles. Wishbone accesses are single-beat
// and acknowledged one cycle after issue.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW         = DMEM_AW,
    parameter logic [31:0] BASE_ADDR  = DMEM_BASE,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n,

    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [3:0]    core_wmask_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [31:0]   core_wdata_i,
    output logic          core_gnt_o,
    output logic          core_rvalid_o,
    output logic [31:0]   core_rdata_o,

    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,

    output logic          sram_csb0_o,
    output logic          sram_web0_o,
    output logic [3:0]    sram_wmask0_o,
    output logic [AW-1:0] sram_addr0_o,
    output logic [31:0]   sram_din0_o,
    input  logic [31:0]   sram_dout0_i
);

    localparam logic [3:0] STARVE_LIM_W = 4'(STARVE_LIM);

    arb_state_t state_q, state_d;
    logic [3:0] starve_q;
    logic       wb_hit, wb_req, wb_prio;
    logic       core_gnt, wb_gnt;
    logic       wb_rd_q;
    logic       adr_lo_unused;

    // Byte offset within a word does not select anything in a word-wide SRAM
    assign adr_lo_unused = ^wbs_adr_i[1:0];

    // Window decode and grant selection; grants are held off while in reset
    // so the macro stays deselected even if a requester is already asserting.
    always_comb begin
        wb_hit   = wbs_stb_i & wbs_cyc_i &
                   (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
        wb_req   = wb_hit & (state_q != WB_ACK);
        wb_prio  = (starve_q >= STARVE_LIM_W);
        core_gnt = wb_rst_n & core_req_i & ~(wb_req & wb_prio);
        wb_gnt   = wb_rst_n & wb_req & ~core_gnt;
    end

    assign core_gnt_o   = core_gnt;
    assign core_rdata_o = sram_dout0_i;
    assign wbs_dat_o    = wb_rd_q ? sram_dout0_i : '0;

    // SRAM port mux: winner drives the port, otherwise the port idles at zero
    always_comb begin
        sram_csb0_o   = CSB_IDLE;
        sram_web0_o   = WEB_IDLE;
        sram_wmask0_o = '0;
        sram_addr0_o  = '0;
        sram_din0_o   = '0;
        if (core_gnt) begin
            sram_csb0_o   = 1'b0;
            sram_web0_o   = ~core_we_i;
            sram_wmask0_o = core_we_i ? core_wmask_i : 4'h0;
            sram_addr0_o  = core_addr_i;
            sram_din0_o   = core_wdata_i;
        end else if (wb_gnt) begin
            sram_csb0_o   = 1'b0;
            sram_web0_o   = ~wbs_we_i;
            sram_wmask0_o = wbs_we_i ? wbs_sel_i : 4'h0;
            sram_addr0_o  = wbs_adr_i[AW+1:2];
            sram_din0_o   = wbs_dat_i;
        end
    end

    // Ack FSM next-state: one WB_ACK cycle follows every Wishbone grant
    always_comb begin
        state_d   = state_q;
        wbs_ack_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_gnt) begin
                    state_d = WB_ACK;
                end
            end
            WB_ACK: begin
                wbs_ack_o = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, starvation counter and read-return tracking
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q       <= IDLE;
            starve_q      <= '0;
            core_rvalid_o <= 1'b0;
            wb_rd_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_rvalid_o <= core_gnt & ~core_we_i;
            wb_rd_q       <= wb_gnt & ~wbs_we_i;
            if (wb_gnt) begin
                starve_q <= '0;
            end else if (wb_req && (starve_q != 4'hF)) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 1-cycle SRAM.
// Inputs change on the falling edge; all outputs are sampled 1ns later.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we;
    logic [3:0]  core_wmask;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        stb, cyc, wbs_we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack;
    logic [31:0] wbs_rdat;
    logic        csb, web;
    logic [3:0]  wmask;
    logic [7:0]  saddr;
    logic [31:0] din, dout;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .AW(8),
        .BASE_ADDR(32'h3000_0000),
        .STARVE_LIM(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_n(rst_n),
        .core_req_i(core_req),
        .core_we_i(core_we),
        .core_wmask_i(core_wmask),
        .core_addr_i(core_addr),
        .core_wdata_i(core_wdata),
        .core_gnt_o(core_gnt),
        .core_rvalid_o(core_rvalid),
        .core_rdata_o(core_rdata),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i(wbs_we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_dat_o(wbs_rdat),
        .sram_csb0_o(csb),
        .sram_web0_o(web),
        .sram_wmask0_o(wmask),
        .sram_addr0_o(saddr),
        .sram_din0_o(din),
        .sram_dout0_i(dout)
    );

    // SRAM macro model: byte-masked write, registered read
    always @(posedge clk) begin
        if (!csb) begin
            if (!web) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask[b]) mem[saddr][b*8 +: 8] <= din[b*8 +: 8];
                end
            end else begin
                dout <= mem[saddr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_sram(input string tag, input logic e_csb, input logic e_web,
                              input logic [3:0] e_mask, input logic [7:0] e_addr);
        check({tag, "_csb"}, csb, e_csb);
        check({tag, "_web"}, web, e_web);
        check({tag, "_wmask"}, wmask, e_mask);
        check({tag, "_addr"}, saddr, e_addr);
    endtask

    task automatic idle_in();
        core_req = 0; core_we = 0; core_wmask = 0; core_addr = 0; core_wdata = 0;
        stb = 0; cyc = 0; wbs_we = 0; sel = 0; adr = 0; dat = 0;
    endtask

    task automatic core_drive(input logic we, input logic [3:0] m, input logic [7:0] a,
                              input logic [31:0] d);
        core_req = 1; core_we = we; core_wmask = m; core_addr = a; core_wdata = d;
    endtask

    task automatic wb_drive(input logic we, input logic [3:0] s, input logic [31:0] a,
                            input logic [31:0] d);
        stb = 1; cyc = 1; wbs_we = we; sel = s; adr = a; dat = d;
    endtask

    task automatic wb_drop();
        stb = 0; cyc = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic e_gnt;
        logic [7:0] e_addr;

        // Reset: port idle even with a core request present
        rst_n = 0;
        idle_in();
        core_drive(0, 4'h0, 8'h10, 32'h0);
        #1;
        check("rst_gnt", core_gnt, 0);
        check_sram("rst", 1, 1, 4'h0, 8'h00);
        check("rst_din", din, 0);
        check("rst_ack", ack, 0);
        check("rst_rvalid", core_rvalid, 0);
        check("rst_wbdat", wbs_rdat, 0);
        @(negedge clk); rst_n = 1; idle_in(); #1;
        check_sram("rel", 1, 1, 4'h0, 8'h00);

        // Core write then read back
        @(negedge clk); core_drive(1, 4'hF, 8'h10, 32'hDEAD_BEEF); #1;
        check("cw_gnt", core_gnt, 1);
        check_sram("cw", 0, 0, 4'hF, 8'h10);
        check("cw_din", din, 32'hDEAD_BEEF);
        @(negedge clk); core_drive(0, 4'hF, 8'h10, 32'h0); #1;
        check("cr_gnt", core_gnt, 1);
        check_sram("cr", 0, 1, 4'h0, 8'h10);
        check("cr_rvalid_early", core_rvalid, 0);
        @(negedge clk); idle_in(); #1;
        check("cr_rvalid", core_rvalid, 1);
        check("cr_rdata", core_rdata, 32'hDEAD_BEEF);
        check("cr_idle_csb", csb, 1);
        @(negedge clk); #1;
        check("cr_rvalid_once", core_rvalid, 0);

        // Back-to-back core accesses, pipelined read returns in order
        @(negedge clk); core_drive(1, 4'hF, 8'h20, 32'hA5A5_0001); #1;
        check("b2b_gnt0", core_gnt, 1);
        @(negedge clk); core_drive(1, 4'hF, 8'h21, 32'h5A5A_0002); #1;
        check("b2b_gnt1", core_gnt, 1);
        @(negedge clk); core_drive(0, 4'h0, 8'h20, 32'h0); #1;
        check("b2b_gnt2", core_gnt, 1);
        check("b2b_nrv_wr", core_rvalid, 0);
        @(negedge clk); core_drive(0, 4'h0, 8'h21, 32'h0); #1;
        check("b2b_gnt3", core_gnt, 1);
        check("b2b_rv0", core_rvalid, 1);
        check("b2b_rd0", core_rdata, 32'hA5A5_0001);
        @(negedge clk); idle_in(); #1;
        check("b2b_rv1", core_rvalid, 1);
        check("b2b_rd1", core_rdata, 32'h5A5A_0002);

        // Wishbone byte write over existing word, then Wishbone read
        @(negedge clk); core_drive(1, 4'hF, 8'h10, 32'h1122_3344); #1;
        @(negedge clk); idle_in(); wb_drive(1, 4'b0010, 32'h3000_0040, 32'h0000_AB00); #1;
        check("wbw_cgnt", core_gnt, 0);
        check_sram("wbw", 0, 0, 4'b0010, 8'h10);
        check("wbw_din", din, 32'h0000_AB00);
        check("wbw_ack_early", ack, 0);
        @(negedge clk); #1;
        check("wbw_ack", ack, 1);
        check("wbw_no_reissue", csb, 1);
        check("wbw_dat", wbs_rdat, 0);
        @(negedge clk); wb_drop(); #1;
        check("wbw_ack_once", ack, 0);
        @(negedge clk); wb_drive(0, 4'hF, 32'h3000_0040, 32'h0); #1;
        check_sram("wbr", 0, 1, 4'h0, 8'h10);
        check("wbr_ack_early", ack, 0);
        @(negedge clk); wb_drop(); #1;
        check("wbr_ack", ack, 1);
        check("wbr_dat", wbs_rdat, 32'h1122_AB44);
        @(negedge clk); #1;
        check("wbr_ack_once", ack, 0);
        check("wbr_dat_clr", wbs_rdat, 0);

        // Contention: core held every cycle, Wishbone wins on 5th pending cycle
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            core_drive(1, 4'hF, 8'h30, i);
            wb_drive(0, 4'hF, 32'h3000_0040, 32'h0);
            #1;
            e_gnt  = (i < 5);
            e_addr = (i < 5) ? 8'h30 : 8'h10;
            check($sformatf("cont1_gnt%0d", i), core_gnt, e_gnt);
            check($sformatf("cont1_addr%0d", i), saddr, e_addr);
        end
        @(negedge clk); core_drive(1, 4'hF, 8'h31, 32'h0); #1;
        check("cont1_ack", ack, 1);
        check("cont1_dat", wbs_rdat, 32'h1122_AB44);
        check("cont1_core_in_ack", core_gnt, 1);
        check("cont1_core_addr", saddr, 8'h31);
        // Counter must have restarted from zero after the Wishbone win
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); #1;
            e_gnt = (i < 5);
            check($sformatf("cont2_gnt%0d", i), core_gnt, e_gnt);
        end
        @(negedge clk); idle_in(); #1;
        check("cont2_ack", ack, 1);

        // Strobe held through ack; core granted during the ack cycle
        @(negedge clk); wb_drive(0, 4'hF, 32'h3000_0040, 32'h0); #1;
        check_sram("sp_a", 0, 1, 4'h0, 8'h10);
        @(negedge clk); core_drive(0, 4'h0, 8'h20, 32'h0); #1;
        check("sp_b_ack", ack, 1);
        check("sp_b_cgnt", core_gnt, 1);
        check_sram("sp_b", 0, 1, 4'h0, 8'h20);
        @(negedge clk); core_req = 0; #1;
        check("sp_c_ack", ack, 0);
        check("sp_c_rvalid", core_rvalid, 1);
        check("sp_c_rdata", core_rdata, 32'hA5A5_0001);
        check("sp_c_wbdat", wbs_rdat, 0);
        check_sram("sp_c", 0, 1, 4'h0, 8'h10);
        @(negedge clk); wb_drop(); #1;
        check("sp_d_ack", ack, 1);
        check("sp_d_dat", wbs_rdat, 32'h1122_AB44);
        check("sp_d_csb", csb, 1);

        // Top word of the window is a hit
        @(negedge clk); wb_drive(1, 4'hF, 32'h3000_03FC, 32'h7777_8888); #1;
        check_sram("top", 0, 0, 4'hF, 8'hFF);
        @(negedge clk); wb_drop(); #1;
        check("top_ack", ack, 1);

        // Misses: outside base region and just past the window end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            wb_drive(0, 4'hF, (i < 20) ? 32'h2000_0000 : 32'h3000_0400, 32'h0);
            #1;
            check($sformatf("miss_csb%0d", i), csb, 1);
            check($sformatf("miss_ack%0d", i), ack, 0);
        end
        @(negedge clk); wb_drop(); #1;

        // Reset asserted while a core read is being issued
        @(negedge clk); core_drive(0, 4'h0, 8'h10, 32'h0); #1;
        check("rr_gnt", core_gnt, 1);
        #2 rst_n = 0; #1;
        check("rr_gnt_rst", core_gnt, 0);
        check("rr_csb_rst", csb, 1);
        @(negedge clk); #1;
        check("rr_rvalid_rst", core_rvalid, 0);
        @(negedge clk); rst_n = 1; idle_in(); #1;
        check("rr_rvalid_rel", core_rvalid, 0);
        @(negedge clk); #1;
        check("rr_rvalid_rel2", core_rvalid, 0);
        check("rr_ack_rel2", ack, 0);

        // Reset asserted while a Wishbone read is being issued
        @(negedge clk); wb_drive(0, 4'hF, 32'h3000_0040, 32'h0); #1;
        check("rw_csb", csb, 0);
        #2 rst_n = 0; #1;
        check("rw_csb_rst", csb, 1);
        @(negedge clk); wb_drop(); rst_n = 1; #1;
        check("rw_ack_rel", ack, 0);
        @(negedge clk); #1;
        check("rw_ack_rel2", ack, 0);
        check("rw_dat_rel2", wbs_rdat, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single read/write port (port 0) of the data SRAM macro (1kB, 32x256, active-low csb/web, 4-bit byte wmask, 1-cycle read latency) between two requesters: the RISC-V core and the Wishbone slave interface.
- Core has default priority. A starvation counter guarantees the Wishbone host a grant after a bounded wait.
- Wishbone accesses are translated into single-beat SRAM cycles and acknowledged one cycle after issue.

Parameters:
- AW, 8, SRAM word-address width (256 words).
- BASE_ADDR, 32'h3000_0000, Wishbone byte base address of the dmem window.
- STARVE_LIM, 4, consecutive lost-contention cycles before Wishbone wins priority (range 1..15).

Ports:
- wb_clk_i  in  1  system clock; all logic on the rising edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- core_req_i  in  1  core access request, held until granted.
- core_we_i  in  1  1 = write.
- core_wmask_i  in  4  byte enables for writes.
- core_addr_i  in  AW  word address.
- core_wdata_i  in  32  write data.
- core_gnt_o  out  1  combinational grant; access is issued this cycle.
- core_rvalid_o  out  1  read data valid (cycle after a read grant).
- core_rdata_o  out  32  read data.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- sram_csb0_o  out  1  chip select, active low.
- sram_web0_o  out  1  write enable, active low.
- sram_wmask0_o  out  4  byte mask.
- sram_addr0_o  out  AW  word address.
- sram_din0_o  out  32  write data.
- sram_dout0_i  in  32  read data from the macro.

Behaviour:
- Reset (async, wb_rst_n=0):
  - FSM state = IDLE; starve_cnt = 0; wbs_ack_o = 0; core_rvalid_o = 0; wbs_dat_o = 0.
  - sram_csb0_o = 1, sram_web0_o = 1; sram_wmask0_o, sram_addr0_o, sram_din0_o = 0.
  - Any in-flight read is dropped: no rvalid and no ack after reset release.
- Wishbone hit:
  - wb_req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]) & (state != WB_ACK).
  - Word address = wbs_adr_i[AW+1:2].
  - Misses are ignored: never acked, never issued.
- Arbitration (combinational, each cycle):
  - wb_prio = (starve_cnt >= STARVE_LIM).
  - Grant core if core_req_i & !(wb_req & wb_prio).
  - Otherwise grant Wishbone if wb_req.
  - At most one grant per cycle.
- SRAM drive, granted cycle:
  - csb0 = 0; web0 = ~we.
  - wmask0 = we ? mask : 4'h0.
  - addr0 and din0 taken from the winner.
- SRAM drive, idle cycle: csb0 = 1, web0 = 1; addr/din/wmask = 0.
- FSM states IDLE, WB_ACK:
  - IDLE -> WB_ACK when Wishbone is granted.
  - WB_ACK -> IDLE unconditionally after one cycle.
  - In WB_ACK: wbs_ack_o = 1 for exactly one cycle, and no new Wishbone grant is issued (master drops stb).
  - Core may be granted during WB_ACK.
- Read latency:
  - Core read granted in cycle N -> core_rvalid_o = 1 in N+1, with core_rdata_o = sram_dout0_i.
  - Core writes produce no rvalid.
  - Wishbone op granted in N -> ack in N+1; for reads wbs_dat_o = sram_dout0_i in N+1, otherwise wbs_dat_o = 0.
- Starvation counter:
  - Increments (saturating at 15) each cycle wb_req=1 and Wishbone is not granted.
  - Clears to 0 on a Wishbone grant.
  - Holds when wb_req=0.
- Simultaneous core and Wishbone requests: core wins unless wb_prio=1. Loser holds its request; core holds core_req_i until core_gnt_o.
- Back-to-back core requests are granted every cycle. Pipelined rvalids are in order, one per read.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state enum {IDLE, WB_ACK};
  - SRAM idle constants (CSB_IDLE=1, WEB_IDLE=1);
  - default DMEM_AW=8 and DMEM_BASE.
- Single module; no sub-module required. The starvation counter and address decode are inline.

Test Plan:
- Reset: hold wb_rst_n=0 mid-read, then release -> csb0=1, ack=0, rvalid=0 throughout; no stale ack after release.
- Core write then read: write addr 8'h10, data 32'hDEAD_BEEF, mask 4'hF; read 8'h10 next cycle -> gnt both cycles, rvalid one cycle after the read with rdata = 32'hDEAD_BEEF.
- Wishbone byte write: write 0x3000_0040 with sel 4'b0010, data 32'h0000_AB00 over existing 32'h1122_3344 -> SRAM wmask 4'b0010, ack next cycle; a later Wishbone read returns 32'h1122_AB44 one cycle after grant.
- Contention: core_req held high every cycle plus a Wishbone read pending -> Wishbone granted exactly on the 5th pending cycle (STARVE_LIM=4); ack the next cycle; starve_cnt back to 0.
- Address miss: Wishbone stb/cyc to 0x2000_0000 -> no SRAM access, wbs_ack_o stays 0 for 20 cycles.
- Ack spacing: Wishbone master keeps stb high through ack -> only one SRAM access per ack; core grant still allowed in the WB_ACK cycle.
